// File: rtl/iob_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// iob_mem_arbiter_if
//   Bus bundle for iob_mem_arbiter: N_REQ packed native-memory requester ports
//   on the s_* side, one native memory port on the m_* side, plus the grant
//   vector and the watchdog error pulse.
//
//   Requester side (packed, requester i at slice i):
//     s_valid, s_addr, s_wdata, s_wstrb   requests toward the arbiter
//     s_rdata, s_ready                    completion back to the requester
//   Memory side:
//     m_valid, m_addr, m_wdata, m_wstrb   registered request toward memory
//     m_rdata, m_ready                    memory completion
//   Status:
//     grant                               one-hot owner, 0 when idle
//     err                                 watchdog-abort pulse
//
//   Modports:
//     slave  - the arbiter's view
//     master - the environment's view (requesters + memory)
// ---------------------------------------------------------------------------
interface iob_mem_arbiter_if #(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int STRB_W = DATA_W / 8;

  logic [N_REQ-1:0]        s_valid;
  logic [N_REQ*ADDR_W-1:0] s_addr;
  logic [N_REQ*DATA_W-1:0] s_wdata;
  logic [N_REQ*STRB_W-1:0] s_wstrb;
  logic [N_REQ*DATA_W-1:0] s_rdata;
  logic [N_REQ-1:0]        s_ready;

  logic                    m_valid;
  logic [ADDR_W-1:0]       m_addr;
  logic [DATA_W-1:0]       m_wdata;
  logic [STRB_W-1:0]       m_wstrb;
  logic [DATA_W-1:0]       m_rdata;
  logic                    m_ready;

  logic [N_REQ-1:0]        grant;
  logic                    err;

  modport slave (
    input  s_valid, s_addr, s_wdata, s_wstrb, m_rdata, m_ready,
    output s_rdata, s_ready, m_valid, m_addr, m_wdata, m_wstrb, grant, err
  );

  modport master (
    output s_valid, s_addr, s_wdata, s_wstrb, m_rdata, m_ready,
    input  s_rdata, s_ready, m_valid, m_addr, m_wdata, m_wstrb, grant, err
  );
endinterface

// File: rtl/iob_mem_arbiter.sv
// ---------------------------------------------------------------------------
// iob_mem_arbiter
//   Round-robin arbiter sharing one native memory port between N_REQ
//   requesters (i-cache, d-cache, DMA, ...). One transaction in flight at a
//   time; the request toward memory (m_valid/m_addr/m_wdata/m_wstrb) is
//   registered, the completion back to the owner (s_ready/s_rdata) is a
//   combinational pass-through of m_ready/m_rdata.
//
// Ports
//   clk   system clock
//   rst   asynchronous, active-low reset
//   bus   iob_mem_arbiter_if.slave (requester side, memory side, grant, err)
//
// Parameters
//   N_REQ   number of requesters (2..8)
//   ADDR_W  address width
//   DATA_W  data width (strobes are DATA_W/8 wide)
//   TIMEOUT watchdog limit in BUSY cycles
//
// Build option
//   IOB_ARB_TIMEOUT_EN  when defined, a watchdog aborts a transaction that
//                       has waited TIMEOUT cycles: the owner gets s_ready
//                       with 0xDEADBEEF data and err pulses for that cycle.
//                       When undefined, BUSY waits forever and err is 0.
// ---------------------------------------------------------------------------
module iob_mem_arbiter #(
  parameter int N_REQ   = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               rst,
  iob_mem_arbiter_if.slave   bus
);
  localparam int STRB_W = DATA_W / 8;
  localparam int IDX_W  = $clog2(N_REQ);
  localparam logic [DATA_W-1:0] ABORT_DATA = DATA_W'(32'hDEADBEEF);

  typedef enum logic {ST_IDLE, ST_BUSY} state_t;

  state_t              state_q;
  logic [IDX_W-1:0]    last_q;      // most recently served requester
  logic [IDX_W-1:0]    owner_q;     // requester of the transaction in flight
  logic [N_REQ-1:0]    grant_q;
  logic                m_valid_q;
  logic [ADDR_W-1:0]   m_addr_q;
  logic [DATA_W-1:0]   m_wdata_q;
  logic [STRB_W-1:0]   m_wstrb_q;

  // -------------------------------------------------------------------------
  // Round-robin pick: first requesting index after last_q, wrapping modulo
  // N_REQ, so the previous owner is the last one considered.
  // -------------------------------------------------------------------------
  logic                pick_found;
  logic [IDX_W-1:0]    pick_idx;
  logic [IDX_W-1:0]    cand;
  logic [ADDR_W-1:0]   pick_addr;
  logic [DATA_W-1:0]   pick_wdata;
  logic [STRB_W-1:0]   pick_wstrb;

  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so
    // no path leaves it unassigned and no latch is inferred.
    pick_found = 1'b0;
    pick_idx   = last_q;
    cand       = last_q;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = IDX_W'((int'(last_q) + k) % N_REQ);
      if (!pick_found && bus.s_valid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    pick_addr  = '0;
    pick_wdata = '0;
    pick_wstrb = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_idx == IDX_W'(i)) begin
        pick_addr  = bus.s_addr [i*ADDR_W +: ADDR_W];
        pick_wdata = bus.s_wdata[i*DATA_W +: DATA_W];
        pick_wstrb = bus.s_wstrb[i*STRB_W +: STRB_W];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Watchdog
  // -------------------------------------------------------------------------
  logic hit_limit;

`ifdef IOB_ARB_TIMEOUT_EN
  localparam int CNT_RAW = $clog2(TIMEOUT);
  localparam int CNT_W   = (CNT_RAW < 10) ? 10 : ((CNT_RAW > 16) ? 16 : CNT_RAW);

  logic [CNT_W-1:0] wait_q;

  // Held at zero while idle, so it is clear on the first BUSY cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_q <= '0;
    end else if (state_q == ST_IDLE) begin
      wait_q <= '0;
    end else if (!bus.m_ready) begin
      wait_q <= wait_q + 1'b1;
    end
  end

  // m_ready in the limit cycle takes precedence: normal completion.
  assign hit_limit = (state_q == ST_BUSY) && !bus.m_ready &&
                     (wait_q == CNT_W'(TIMEOUT - 1));
`else
  assign hit_limit = 1'b0;
`endif

  logic done;
  assign done = (state_q == ST_BUSY) && (bus.m_ready || hit_limit);

  // -------------------------------------------------------------------------
  // Completion routing: only the owner's slice carries data or s_ready.
  // -------------------------------------------------------------------------
  logic [N_REQ-1:0]        s_ready_d;
  logic [N_REQ*DATA_W-1:0] s_rdata_d;

  always_comb begin
    s_ready_d = '0;
    s_rdata_d = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (done && owner_q == IDX_W'(i)) begin
        s_ready_d[i]                  = 1'b1;
        s_rdata_d[i*DATA_W +: DATA_W] = bus.m_ready ? bus.m_rdata : ABORT_DATA;
      end
    end
  end

  // -------------------------------------------------------------------------
  // FSM with registered memory-side outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      last_q    <= IDX_W'(N_REQ - 1);
      owner_q   <= '0;
      grant_q   <= '0;
      m_valid_q <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      m_wstrb_q <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every register
      // samples pre-edge values, independent of statement order.
      case (state_q)
        ST_IDLE: begin
          if (pick_found) begin
            state_q   <= ST_BUSY;
            owner_q   <= pick_idx;
            grant_q   <= N_REQ'(1) << pick_idx;
            m_valid_q <= 1'b1;
            m_addr_q  <= pick_addr;
            m_wdata_q <= pick_wdata;
            m_wstrb_q <= pick_wstrb;
          end
        end
        ST_BUSY: begin
          // A requester dropping s_valid here does not cancel anything.
          if (done) begin
            state_q   <= ST_IDLE;
            m_valid_q <= 1'b0;
            grant_q   <= '0;
            last_q    <= owner_q;
          end
        end
      endcase
    end
  end

  assign bus.m_valid = m_valid_q;
  assign bus.m_addr  = m_addr_q;
  assign bus.m_wdata = m_wdata_q;
  assign bus.m_wstrb = m_wstrb_q;
  assign bus.grant   = grant_q;
  assign bus.s_ready = s_ready_d;
  assign bus.s_rdata = s_rdata_d;
  assign bus.err     = hit_limit;

endmodule

// File: tb/tb_iob_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_iob_mem_arbiter
//   Self-checking bench for iob_mem_arbiter with three requesters. Inputs are
//   driven and outputs sampled on the falling clock edge; combinational
//   completion outputs are sampled 1 time unit after the inputs change.
// ---------------------------------------------------------------------------
module tb_iob_mem_arbiter;
  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_pass   = 0;

  iob_mem_arbiter_if #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

  iob_mem_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic [N-1:0]  mask;
    int            g;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
    int            lat;
    logic [DW-1:0] rdata;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [N-1:0] onehot(input int i);
    onehot = N'(1) << i;
  endfunction

  function automatic logic [DW-1:0] rd_slice(input int i);
    rd_slice = bus.s_rdata[i*DW +: DW];
  endfunction

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [SW-1:0] s);
    bus.s_addr [i*AW +: AW] = a;
    bus.s_wdata[i*DW +: DW] = d;
    bus.s_wstrb[i*SW +: SW] = s;
  endtask

  task automatic idle_inputs();
    bus.s_valid = '0;
    bus.s_addr  = '0;
    bus.s_wdata = '0;
    bus.s_wstrb = '0;
    bus.m_ready = 1'b0;
    bus.m_rdata = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // T1: outputs held quiet under reset even with requests present.
  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    bus.s_valid = 3'b011;
    bus.m_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      #1;
      check("rst_m_valid", bus.m_valid, 0);
      check("rst_grant",   bus.grant,   0);
      check("rst_s_ready", bus.s_ready, 0);
      check("rst_err",     bus.err,     0);
    end
    check("rst_m_addr",  bus.m_addr,  0);
    check("rst_m_wdata", bus.m_wdata, 0);
    check("rst_m_wstrb", bus.m_wstrb, 0);
    idle_inputs();
    rst = 1'b1;
  endtask

  // Table-driven single transactions; starting round-robin pointer is N-1.
  task automatic test_vectors();
    vec_t v;
    for (int n = 0; n < 8; n++) begin
      v = vecs[n];
      @(negedge clk);
      check("vec_idle_m_valid", bus.m_valid, 0);
      check("vec_idle_grant",   bus.grant,   0);
      for (int i = 0; i < N; i++) begin
        if (i == v.g) set_req(i, v.addr, v.wdata, v.wstrb);
        else          set_req(i, ~v.addr, ~v.wdata, ~v.wstrb);
      end
      bus.s_valid = v.mask;
      @(negedge clk);
      check("vec_m_valid", bus.m_valid, 1);
      check("vec_grant",   bus.grant,   onehot(v.g));
      check("vec_m_addr",  bus.m_addr,  v.addr);
      check("vec_m_wdata", bus.m_wdata, v.wdata);
      check("vec_m_wstrb", bus.m_wstrb, v.wstrb);
      check("vec_s_ready_early", bus.s_ready, 0);
      for (int w = 0; w < v.lat; w++) begin
        @(negedge clk);
        check("vec_wait_m_valid", bus.m_valid, 1);
        check("vec_wait_m_addr",  bus.m_addr,  v.addr);
        check("vec_wait_s_ready", bus.s_ready, 0);
      end
      bus.m_ready = 1'b1;
      bus.m_rdata = v.rdata;
      #1;
      check("vec_s_ready", bus.s_ready, onehot(v.g));
      check("vec_s_rdata", rd_slice(v.g), v.rdata);
      for (int i = 0; i < N; i++)
        if (i != v.g) check("vec_s_rdata_other", rd_slice(i), 0);
      check("vec_err", bus.err, 0);
      @(negedge clk);
      bus.m_ready = 1'b0;
      bus.s_valid = '0;
      check("vec_done_m_valid", bus.m_valid, 0);
      check("vec_done_grant",   bus.grant,   0);
      #1;
      check("vec_done_s_ready", bus.s_ready, 0);
    end
  endtask

  // T3: two requesters held high from reset must alternate strictly.
  task automatic test_contention();
    logic [N-1:0] got [$];
    do_reset();
    set_req(0, 32'h1000, 32'h0, 4'h0);
    set_req(1, 32'h2000, 32'h0, 4'h0);
    bus.s_valid = 3'b011;
    for (int cyc = 0; cyc < 60 && got.size() < 6; cyc++) begin
      @(negedge clk);
      if (bus.m_valid) begin
        got.push_back(bus.grant);
        bus.m_ready = 1'b1;
        bus.m_rdata = DW'(cyc);
      end else begin
        bus.m_ready = 1'b0;
      end
    end
    @(negedge clk);
    bus.m_ready = 1'b0;
    bus.s_valid = '0;
    check("rr_count", got.size(), 6);
    for (int k = 0; k < got.size(); k++)
      check("rr_order", got[k], (k % 2 == 0) ? 3'b001 : 3'b010);
  endtask

  // T5: abandoned request still completes; reset mid-transaction drops it.
  task automatic test_abandon_reset();
    @(negedge clk);
    set_req(0, 32'h200, 32'h0, 4'h0);
    bus.s_valid = 3'b001;
    @(negedge clk);
    check("abn_grant", bus.grant, 3'b001);
    bus.s_valid = '0;
    @(negedge clk);
    check("abn_m_valid_held", bus.m_valid, 1);
    bus.m_ready = 1'b1;
    bus.m_rdata = 32'hA5A50001;
    #1;
    check("abn_s_ready", bus.s_ready, 3'b001);
    check("abn_s_rdata", rd_slice(0), 32'hA5A50001);
    @(negedge clk);
    bus.m_ready = 1'b0;
    check("abn_done_m_valid", bus.m_valid, 0);

    set_req(1, 32'h300, 32'h77, 4'hF);
    bus.s_valid = 3'b010;
    @(negedge clk);
    check("mid_rst_grant_before", bus.grant, 3'b010);
    bus.m_ready = 1'b1;
    rst = 1'b0;
    #1;
    check("mid_rst_m_valid", bus.m_valid, 0);
    check("mid_rst_grant",   bus.grant,   0);
    check("mid_rst_s_ready", bus.s_ready, 0);
    bus.s_valid = '0;
    @(negedge clk);
    bus.m_ready = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, AW'(32'h400 + i), DW'(i), 4'h0);
    bus.s_valid = 3'b111;
    @(negedge clk);
    check("post_rst_grant",  bus.grant,  3'b001);
    check("post_rst_m_addr", bus.m_addr, 32'h400);
    bus.m_ready = 1'b1;
    #1;
    check("post_rst_s_ready", bus.s_ready, 3'b001);
    @(negedge clk);
    bus.m_ready = 1'b0;
    bus.s_valid = '0;
  endtask

  // T6: watchdog behaviour (or its absence in the default build).
  task automatic test_timeout();
    int seen;
    seen = 0;
    @(negedge clk);
    set_req(2, 32'h700, 32'h11, 4'hF);
    bus.s_valid = 3'b100;
    @(negedge clk);
    check("to_grant", bus.grant, 3'b100);
`ifdef IOB_ARB_TIMEOUT_EN
    for (int c = 1; c < TO; c++) begin
      #1;
      if (bus.err || bus.s_ready != 0) seen++;
      @(negedge clk);
    end
    check("to_early_events", seen, 0);
    #1;
    check("to_err",     bus.err,     1);
    check("to_s_ready", bus.s_ready, 3'b100);
    check("to_s_rdata", rd_slice(2), 32'hDEADBEEF);
    @(negedge clk);
    bus.s_valid = '0;
    check("to_m_valid_after", bus.m_valid, 0);
    check("to_grant_after",   bus.grant,   0);
    #1;
    check("to_err_after", bus.err, 0);

    // m_ready arriving exactly at the limit wins.
    set_req(0, 32'h800, 32'h0, 4'h0);
    bus.s_valid = 3'b001;
    @(negedge clk);
    check("to_win_grant", bus.grant, 3'b001);
    for (int c = 1; c < TO; c++) @(negedge clk);
    bus.m_ready = 1'b1;
    bus.m_rdata = 32'h0000600D;
    #1;
    check("to_win_err",     bus.err,     0);
    check("to_win_s_ready", bus.s_ready, 3'b001);
    check("to_win_s_rdata", rd_slice(0), 32'h0000600D);
    @(negedge clk);
    bus.m_ready = 1'b0;
    bus.s_valid = '0;
    check("to_win_m_valid_after", bus.m_valid, 0);
`else
    for (int c = 0; c < 3 * TO; c++) begin
      #1;
      if (bus.err || bus.s_ready != 0 || !bus.m_valid) seen++;
      @(negedge clk);
    end
    check("nto_no_abort", seen, 0);
    bus.m_ready = 1'b1;
    bus.m_rdata = 32'h13579BDF;
    #1;
    check("nto_s_ready", bus.s_ready, 3'b100);
    check("nto_s_rdata", rd_slice(2), 32'h13579BDF);
    check("nto_err",     bus.err,     0);
    @(negedge clk);
    bus.m_ready = 1'b0;
    bus.s_valid = '0;
    check("nto_m_valid_after", bus.m_valid, 0);
`endif
  endtask

  // Random traffic against a transaction-level model: pending requesters,
  // a rotating "last served" index, and per-requester waiting counts.
  task automatic run_random(input int cycles);
    logic [N-1:0]  req_on, prev_valid, exp_ready;
    logic [AW-1:0] r_addr  [N];
    logic [DW-1:0] r_wdata [N];
    logic [SW-1:0] r_wstrb [N];
    int            wait_txn [N];
    bit            busy, prev_mready;
    int            owner, last, lat_left, n_txn, c;
    do_reset();
    req_on = '0; prev_valid = '0; busy = 0; prev_mready = 0;
    owner = 0; last = N - 1; lat_left = 0; n_txn = 0;
    for (int i = 0; i < N; i++) begin
      r_addr[i] = '0; r_wdata[i] = '0; r_wstrb[i] = '0; wait_txn[i] = 0;
    end
    for (int cyc = 0; cyc < cycles; cyc++) begin
      @(negedge clk);
      // Effect of the clock edge just passed.
      if (busy) begin
        if (prev_mready) begin
          busy = 0;
          last = owner;
          req_on[owner] = 1'b0;
        end
      end else begin
        for (int k = 1; k <= N; k++) begin
          c = (last + k) % N;
          if (!busy && prev_valid[c]) begin
            busy  = 1;
            owner = c;
          end
        end
        if (busy) begin
          n_txn++;
          lat_left = $urandom_range(0, 4);
          for (int i = 0; i < N; i++) begin
            if (i != owner && prev_valid[i]) begin
              wait_txn[i]++;
              check("rnd_fairness", wait_txn[i] <= N - 1, 1);
            end
          end
          wait_txn[owner] = 0;
        end
      end
      check("rnd_m_valid", bus.m_valid, busy);
      check("rnd_grant",   bus.grant,   busy ? onehot(owner) : '0);
      if (busy) begin
        check("rnd_m_addr",  bus.m_addr,  r_addr[owner]);
        check("rnd_m_wdata", bus.m_wdata, r_wdata[owner]);
        check("rnd_m_wstrb", bus.m_wstrb, r_wstrb[owner]);
      end
      // New stimulus.
      for (int i = 0; i < N; i++) begin
        if (!req_on[i] && $urandom_range(0, 3) == 0) begin
          req_on[i]   = 1'b1;
          r_addr[i]   = $urandom;
          r_wdata[i]  = $urandom;
          r_wstrb[i]  = ($urandom_range(0, 1) == 1) ? '0 : SW'($urandom);
          wait_txn[i] = 0;
          set_req(i, r_addr[i], r_wdata[i], r_wstrb[i]);
        end
      end
      bus.s_valid = req_on;
      if (busy) begin
        bus.m_ready = (lat_left == 0);
        if (lat_left > 0) lat_left--;
      end else begin
        bus.m_ready = ($urandom_range(0, 1) == 1);
      end
      bus.m_rdata = $urandom;
      #1;
      exp_ready = (busy && bus.m_ready) ? onehot(owner) : '0;
      check("rnd_s_ready", bus.s_ready, exp_ready);
      for (int i = 0; i < N; i++)
        check("rnd_s_rdata", rd_slice(i), exp_ready[i] ? bus.m_rdata : '0);
      check("rnd_err", bus.err, 0);
      prev_valid  = req_on;
      prev_mready = bus.m_ready;
    end
    check("rnd_txn_activity", n_txn > cycles / 20, 1);
    bus.s_valid = '0;
    repeat (10) begin
      @(negedge clk);
      bus.m_ready = bus.m_valid;
    end
    bus.m_ready = 1'b0;
    @(negedge clk);
    check("rnd_drain_m_valid", bus.m_valid, 0);
  endtask

  initial begin
    vecs[0] = '{mask: 3'b001, g: 0, addr: 32'h100, wdata: 32'h0,        wstrb: 4'b0000, lat: 2, rdata: 32'h12345678};
    vecs[1] = '{mask: 3'b010, g: 1, addr: 32'h40,  wdata: 32'hCAFEF00D, wstrb: 4'b0011, lat: 0, rdata: 32'h0};
    vecs[2] = '{mask: 3'b111, g: 2, addr: 32'h2C0, wdata: 32'h0BADCAFE, wstrb: 4'b1111, lat: 1, rdata: 32'h87654321};
    vecs[3] = '{mask: 3'b011, g: 0, addr: 32'h3A4, wdata: 32'h0,        wstrb: 4'b0000, lat: 3, rdata: 32'hFEEDFACE};
    vecs[4] = '{mask: 3'b101, g: 2, addr: 32'h5F0, wdata: 32'h11223344, wstrb: 4'b1000, lat: 0, rdata: 32'h0};
    vecs[5] = '{mask: 3'b110, g: 1, addr: 32'h608, wdata: 32'h0,        wstrb: 4'b0000, lat: 1, rdata: 32'hA0B0C0D0};
    vecs[6] = '{mask: 3'b100, g: 2, addr: 32'h71C, wdata: 32'h55AA55AA, wstrb: 4'b0101, lat: 2, rdata: 32'h0};
    vecs[7] = '{mask: 3'b011, g: 0, addr: 32'h820, wdata: 32'h0,        wstrb: 4'b0000, lat: 0, rdata: 32'h31415926};

    test_reset();
    test_vectors();
    test_contention();
    test_abandon_reset();
    test_timeout();
    run_random(3000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
